// File: rtl/uart_to_frame_if.sv
// Byte-in / frame-out signal bundle between the UART receiver, the frame
// assembler and the DMA-SPI test logic.
interface uart_to_frame_if #(
  parameter int N_BYTES = 51
) ();
  localparam int W = N_BYTES * 8;

  logic [7:0]   DATA_in;
  logic         RX_VALID;
  logic [W-1:0] data_out;
  logic         RCV;
  logic         BUSY;
  logic         ERR_TO;
  logic [7:0]   byte_cnt;

  modport master (
    output DATA_in, RX_VALID,
    input  data_out, RCV, BUSY, ERR_TO, byte_cnt
  );

  modport slave (
    input  DATA_in, RX_VALID,
    output data_out, RCV, BUSY, ERR_TO, byte_cnt
  );
endinterface

// File: rtl/uart_to_frame.sv
// Assembles UART bytes into one N_BYTES-wide frame (first byte in the MS byte),
// flags completion with RCV and drops partial frames on inter-byte timeout.
module uart_to_frame #(
  parameter int N_BYTES     = 51,
  parameter int TIMEOUT_CLK = 100000
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_to_frame_if.slave bus
);
  localparam int W  = N_BYTES * 8;
  localparam bit TO_EN = (TIMEOUT_CLK > 0);
  localparam int TW = TO_EN ? $clog2(TIMEOUT_CLK + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TO_EN ? TW'(TIMEOUT_CLK - 1) : '0;
  localparam logic [TW-1:0] TO_SAT  = TO_EN ? TW'(TIMEOUT_CLK) : '0;
  localparam logic [7:0]    CNT_LAST = 8'(N_BYTES - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   sr_reg, sr_next;
  logic [W-1:0]   data_out_reg, data_out_next;
  logic           rcv_reg, rcv_next;
  logic           err_reg, err_next;
  logic [7:0]     cnt_reg, cnt_next;
  logic [TW-1:0]  to_reg, to_next;
  logic [W-1:0]   shift_in;

  // A one-byte frame has no older bytes to keep, so the slice would be empty.
  generate
    if (N_BYTES == 1) begin : g_single
      assign shift_in = bus.DATA_in;
    end else begin : g_multi
      assign shift_in = {sr_reg[W-9:0], bus.DATA_in};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      sr_reg       <= '0;
      data_out_reg <= '0;
      rcv_reg      <= 1'b0;
      err_reg      <= 1'b0;
      cnt_reg      <= '0;
      to_reg       <= '0;
    end else begin
      state_reg    <= state_next;
      sr_reg       <= sr_next;
      data_out_reg <= data_out_next;
      rcv_reg      <= rcv_next;
      err_reg      <= err_next;
      cnt_reg      <= cnt_next;
      to_reg       <= to_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    sr_next       = sr_reg;
    data_out_next = data_out_reg;
    rcv_next      = 1'b0;
    err_next      = 1'b0;
    cnt_next      = cnt_reg;
    to_next       = '0;

    // An arriving byte always wins over a timeout expiring on the same clock.
    if (bus.RX_VALID) begin
      sr_next = shift_in;
      if (cnt_reg == CNT_LAST) begin
        data_out_next = shift_in;
        rcv_next      = 1'b1;
        cnt_next      = '0;
        state_next    = IDLE;
      end else begin
        cnt_next   = cnt_reg + 8'd1;
        state_next = COLLECT;
      end
    end else if (state_reg == COLLECT && TO_EN) begin
      if (to_reg == TO_LAST) begin
        err_next   = 1'b1;
        cnt_next   = '0;
        sr_next    = '0;
        state_next = IDLE;
      end else if (to_reg != TO_SAT) begin
        to_next = to_reg + 1'b1;
      end else begin
        to_next = to_reg;
      end
    end
  end

  assign bus.data_out = data_out_reg;
  assign bus.RCV      = rcv_reg;
  assign bus.ERR_TO   = err_reg;
  assign bus.BUSY     = (state_reg == COLLECT);
  assign bus.byte_cnt = cnt_reg;
endmodule
